// File: rtl/alu_exec_if.sv
// Operand/result handshake bundle for alu_exec_unit (slave = ALU, master = issue/consumer side).
// The ovf signal exists only when ALU_OVF_FLAG_EN is defined.
interface alu_exec_if #(parameter int W = 32);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_funct;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;
  logic         dbg_state;
`ifdef ALU_OVF_FLAG_EN
  logic         ovf;
`endif

  modport master (
    output in_valid, alu_funct, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, busy, dbg_state
`ifdef ALU_OVF_FLAG_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, alu_funct, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, busy, dbg_state
`ifdef ALU_OVF_FLAG_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle add/sub/slt/logic ops, iterative 1-bit-per-cycle srl.
// Optional registered signed-overflow flag when ALU_OVF_FLAG_EN is defined.
module alu_exec_unit #(
  parameter int W = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_exec_if.slave bus
);
  localparam int SW = $clog2(W);

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_SLT = 3'b010;
  localparam logic [2:0] F_AND = 3'b011;
  localparam logic [2:0] F_OR  = 3'b100;
  localparam logic [2:0] F_XOR = 3'b101;
  localparam logic [2:0] F_NOR = 3'b110;
  localparam logic [2:0] F_SRL = 3'b111;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t       state;
  logic [W-1:0] shift_q;
  logic [SW-1:0] cnt_q;
  logic [W-1:0] result_q;
  logic         zero_q;
  logic         valid_q;
  logic         busy_q;

  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic [W-1:0] comb_res;
  logic [W-1:0] shift_nxt;
  logic [SW-1:0] shamt;
  logic         lt;
  logic         accept;

  // Handshake: a word moves on any rising edge where valid & ready are both high;
  // ready never depends on valid, and valid/data hold until the transfer.
  assign bus.in_ready  = rst_n && (state == IDLE) && (!valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state;

  assign shamt     = bus.op_b[SW-1:0];
  assign sum       = bus.op_a + bus.op_b;
  assign diff      = bus.op_a - bus.op_b;
  assign lt        = $signed(bus.op_a) < $signed(bus.op_b);
  assign shift_nxt = shift_q >> 1;

  always_comb begin
    comb_res = '0;
    case (bus.alu_funct)
      F_ADD: comb_res = sum;
      F_SUB: comb_res = diff;
      F_SLT: comb_res = {{(W-1){1'b0}}, lt};
      F_AND: comb_res = bus.op_a & bus.op_b;
      F_OR:  comb_res = bus.op_a | bus.op_b;
      F_XOR: comb_res = bus.op_a ^ bus.op_b;
      F_NOR: comb_res = ~(bus.op_a | bus.op_b);
      F_SRL: comb_res = bus.op_a; // only loaded directly when shamt == 0
    endcase
  end

`ifdef ALU_OVF_FLAG_EN
  logic ovf_q;
  logic comb_ovf;

  always_comb begin
    comb_ovf = 1'b0;
    if (bus.alu_funct == F_ADD)
      comb_ovf = (bus.op_a[W-1] == bus.op_b[W-1]) && (sum[W-1] != bus.op_a[W-1]);
    else if (bus.alu_funct == F_SUB)
      comb_ovf = (bus.op_a[W-1] != bus.op_b[W-1]) && (diff[W-1] != bus.op_a[W-1]);
  end

  assign bus.ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      // Drain first; a load in the same cycle overrides it below.
      if (valid_q && bus.out_ready)
        valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.alu_funct == F_SRL && shamt != '0) begin
              shift_q <= bus.op_a;
              cnt_q   <= shamt;
              busy_q  <= 1'b1;
              state   <= SHIFT;
            end else begin
              result_q <= comb_res;
              zero_q   <= (comb_res == '0);
              valid_q  <= 1'b1;
`ifdef ALU_OVF_FLAG_EN
              ovf_q    <= comb_ovf;
`endif
            end
          end
        end
        SHIFT: begin
          shift_q <= shift_nxt;
          cnt_q   <= cnt_q - SW'(1);
          if (cnt_q == SW'(1)) begin
            result_q <= shift_nxt;
            zero_q   <= (shift_nxt == '0);
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            state    <= IDLE;
`ifdef ALU_OVF_FLAG_EN
            ovf_q    <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
